// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: per-source enable and edge/level
// mode, latched pending bits, fixed priority, vector/ack handshake.
module irq_controller #(
  parameter int          NUM_SRC    = 8,
  parameter int          VEC_W      = 4,
  parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_0000_FF00,
  parameter logic [NUM_SRC-1:0] ENABLE_RST = '1,
  parameter logic [NUM_SRC-1:0] MODE_RST   = '1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic [VEC_W-1:0]   interrupt_vector,
  input  logic               interrupt_ack,
  input  logic [63:0]        bus_address,
  input  logic [63:0]        bus_write_data,
  input  logic               bus_write_enable,
  input  logic               bus_read_enable,
  output logic [63:0]        bus_read_data,
  output logic               bus_selected,
  output logic               irq_any
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRES,
    S_GAP
  } state_t;

  state_t             r_state;
  logic [VEC_W-1:0]   r_vec;
  logic [NUM_SRC-1:0] r_s1;
  logic [NUM_SRC-1:0] r_s2;
  logic [NUM_SRC-1:0] r_hist;
  logic [NUM_SRC-1:0] r_pnd;
  logic [NUM_SRC-1:0] r_en;
  logic [NUM_SRC-1:0] r_mode;
  logic [63:0]        r_rdata;
  logic               r_any;

  logic [63:0]        w_off;
  logic               w_sel;
  logic               w_wr;
  logic               w_rd;
  logic [1:0]         w_reg;
  logic [NUM_SRC-1:0] w_wdata;
  logic [NUM_SRC-1:0] w_rise;
  logic [NUM_SRC-1:0] w_act;
  logic [NUM_SRC-1:0] w_w1c;
  logic [NUM_SRC-1:0] w_en_nxt;
  logic [NUM_SRC-1:0] w_mode_nxt;
  logic [NUM_SRC-1:0] w_ack_clr;
  logic [NUM_SRC-1:0] w_pnd_nxt;
  logic [VEC_W-1:0]   w_lo;
  logic [63:0]        w_rmux;
  logic               w_unused;

  // Addresses below the base wrap to huge offsets, so one compare suffices
  assign w_off   = bus_address - BASE_ADDR;
  assign w_sel   = (w_off < 64'd32);
  assign w_reg   = w_off[4:3];
  assign w_wr    = w_sel & bus_write_enable;
  assign w_rd    = w_sel & bus_read_enable;
  assign w_wdata = bus_write_data[NUM_SRC-1:0];
  assign w_unused = ^{w_off[2:0], bus_write_data};

  assign w_rise = r_s2 & ~r_hist;
  assign w_act  = r_pnd & r_en;

  assign w_w1c = (w_wr && w_reg == 2'd0) ? (w_wdata & r_mode) : '0;
  assign w_en_nxt   = (w_wr && w_reg == 2'd1) ? w_wdata : r_en;
  assign w_mode_nxt = (w_wr && w_reg == 2'd2) ? w_wdata : r_mode;

  always_comb begin
    w_ack_clr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (r_state == S_PRES && interrupt_ack &&
          r_vec == VEC_W'(i + 1))
        w_ack_clr[i] = r_mode[i];
    end
  end

  // A fresh edge beats any clear in the same cycle
  always_comb begin
    w_pnd_nxt = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_mode_nxt[i] != r_mode[i])
        w_pnd_nxt[i] = 1'b0;
      else if (r_mode[i])
        w_pnd_nxt[i] = (r_pnd[i] & ~(w_w1c[i] | w_ack_clr[i]))
                     | w_rise[i];
      else
        w_pnd_nxt[i] = r_s2[i];
    end
  end

  always_comb begin
    w_lo = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_act[i])
        w_lo = VEC_W'(i + 1);
    end
  end

  always_comb begin
    w_rmux = '0;
    unique case (w_reg)
      2'd0: w_rmux[NUM_SRC-1:0] = r_pnd;
      2'd1: w_rmux[NUM_SRC-1:0] = r_en;
      2'd2: w_rmux[NUM_SRC-1:0] = r_mode;
      2'd3: w_rmux[VEC_W-1:0]   = r_vec;
      default: w_rmux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_hist <= '0;
      r_pnd  <= '0;
      r_en   <= ENABLE_RST;
      r_mode <= MODE_RST;
      r_any  <= 1'b0;
    end else begin
      r_s1   <= irq_src;
      r_s2   <= r_s1;
      r_hist <= r_s2;
      r_pnd  <= w_pnd_nxt;
      r_en   <= w_en_nxt;
      r_mode <= w_mode_nxt;
      r_any  <= |w_act;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_rdata <= '0;
    else if (w_rd)
      r_rdata <= w_rmux;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_vec   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (|w_act) begin
            r_vec   <= w_lo;
            r_state <= S_PRES;
          end
        end
        S_PRES: begin
          if (interrupt_ack) begin
            r_vec   <= '0;
            r_state <= S_GAP;
          end
        end
        S_GAP: r_state <= S_IDLE;
        default: begin
          r_state <= S_IDLE;
          r_vec   <= '0;
        end
      endcase
    end
  end

  assign interrupt_vector = r_vec;
  assign bus_read_data    = r_rdata;
  assign bus_selected     = w_sel;
  assign irq_any          = r_any;

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed scenarios plus random traffic,
// all outputs compared every cycle against a behavioural model.
module tb_irq_controller;

  localparam int N = 8;
  localparam logic [63:0] BASE = 64'h0000_0000_0000_FF00;

  logic        clk;
  logic        reset_n;
  logic [N-1:0] irq_src;
  logic [3:0]  interrupt_vector;
  logic        interrupt_ack;
  logic [63:0] bus_address;
  logic [63:0] bus_write_data;
  logic        bus_write_enable;
  logic        bus_read_enable;
  logic [63:0] bus_read_data;
  logic        bus_selected;
  logic        irq_any;

  int total = 0;
  int bad   = 0;

  irq_controller dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .irq_src          (irq_src),
    .interrupt_vector (interrupt_vector),
    .interrupt_ack    (interrupt_ack),
    .bus_address      (bus_address),
    .bus_write_data   (bus_write_data),
    .bus_write_enable (bus_write_enable),
    .bus_read_enable  (bus_read_enable),
    .bus_read_data    (bus_read_data),
    .bus_selected     (bus_selected),
    .irq_any          (irq_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  // Behavioural model: sources seen through a 3-sample delay line
  logic [N-1:0] s0, s1, s2;
  logic [N-1:0] m_pnd, m_en, m_mode;
  int           m_vec, m_gap;
  logic [63:0]  m_rd;
  logic         m_any;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s0 <= '0; s1 <= '0; s2 <= '0;
      m_pnd <= '0; m_en <= '1; m_mode <= '1;
      m_vec <= 0; m_gap <= 0; m_rd <= '0; m_any <= 1'b0;
    end else begin
      automatic logic [N-1:0] sync = s1;
      automatic logic [N-1:0] rise = s1 & ~s2;
      automatic logic [N-1:0] act  = m_pnd & m_en;
      automatic logic [N-1:0] clr  = '0;
      automatic logic [N-1:0] nen  = m_en;
      automatic logic [N-1:0] nmd  = m_mode;
      automatic logic [N-1:0] np   = '0;
      automatic int nvec = m_vec;
      automatic int ngap = m_gap;
      automatic bit sel = (bus_address >= BASE) &&
                          (bus_address < BASE + 64'd32);
      automatic int rg = int'((bus_address - BASE) / 8) % 4;
      if (sel && bus_read_enable) begin
        case (rg)
          0: m_rd <= 64'(m_pnd);
          1: m_rd <= 64'(m_en);
          2: m_rd <= 64'(m_mode);
          default: m_rd <= 64'(m_vec);
        endcase
      end
      if (sel && bus_write_enable) begin
        case (rg)
          0: clr = bus_write_data[N-1:0] & m_mode;
          1: nen = bus_write_data[N-1:0];
          2: nmd = bus_write_data[N-1:0];
          default: ;
        endcase
      end
      if (m_vec != 0) begin
        if (interrupt_ack) begin
          if (m_mode[m_vec-1]) clr[m_vec-1] = 1'b1;
          nvec = 0;
          ngap = 1;
        end
      end else if (m_gap != 0) begin
        ngap = 0;
      end else if (act != 0) begin
        for (int i = N - 1; i >= 0; i--)
          if (act[i]) nvec = i + 1;
      end
      for (int i = 0; i < N; i++) begin
        if (nmd[i] != m_mode[i]) np[i] = 1'b0;
        else if (m_mode[i]) np[i] = (m_pnd[i] & ~clr[i]) | rise[i];
        else np[i] = sync[i];
      end
      m_pnd <= np; m_en <= nen; m_mode <= nmd;
      m_vec <= nvec; m_gap <= ngap; m_any <= (act != 0);
      s2 <= s1; s1 <= s0; s0 <= irq_src;
    end
  end

  always @(negedge clk) begin
    chk("vector", 64'(interrupt_vector), 64'(m_vec));
    chk("rdata", bus_read_data, m_rd);
    chk("irq_any", 64'(irq_any), 64'(m_any));
    chk("selected", 64'(bus_selected),
        64'((bus_address >= BASE) && (bus_address < BASE + 64'd32)));
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] off, output logic [63:0] d);
    bus_address = BASE + 64'(off);
    bus_read_enable = 1'b1;
    cyc(1);
    bus_read_enable = 1'b0;
    d = bus_read_data;
  endtask

  task automatic wr(input logic [4:0] off, input logic [63:0] d);
    bus_address = BASE + 64'(off);
    bus_write_data = d;
    bus_write_enable = 1'b1;
    cyc(1);
    bus_write_enable = 1'b0;
  endtask

  task automatic ack();
    interrupt_ack = 1'b1;
    cyc(1);
    interrupt_ack = 1'b0;
  endtask

  task automatic wait_vec(input logic [3:0] e, input int max);
    for (int i = 0; i < max; i++) begin
      if (interrupt_vector == e) break;
      cyc(1);
    end
    chk("wait_vec", 64'(interrupt_vector), 64'(e));
  endtask

  logic [63:0] d;

  initial begin
    reset_n = 1'b0;
    irq_src = '0;
    interrupt_ack = 1'b0;
    bus_address = '0;
    bus_write_data = '0;
    bus_write_enable = 1'b0;
    bus_read_enable = 1'b0;
    cyc(2);
    chk("rst_vec", 64'(interrupt_vector), 0);
    chk("rst_rdata", bus_read_data, 0);
    chk("rst_any", 64'(irq_any), 0);
    reset_n = 1'b1;
    cyc(1);
    rd(5'h08, d); chk("rst_enable", d, 64'hFF);
    rd(5'h10, d); chk("rst_mode", d, 64'hFF);
    rd(5'h18, d); chk("rst_claim", d, 64'h0);

    irq_src = 8'h24;
    cyc(3); chk("prio_early", 64'(interrupt_vector), 0);
    cyc(1); chk("prio_vec3", 64'(interrupt_vector), 3);
    chk("prio_any", 64'(irq_any), 1);
    rd(5'h18, d); chk("claim3", d, 64'h3);
    ack(); chk("gap1a", 64'(interrupt_vector), 0);
    cyc(1); chk("gap1b", 64'(interrupt_vector), 0);
    cyc(1); chk("prio_vec6", 64'(interrupt_vector), 6);
    cyc(2);
    irq_src = 8'h00;
    ack(); chk("gap2", 64'(interrupt_vector), 0);
    cyc(3);
    rd(5'h00, d); chk("prio_pend0", d, 64'h0);
    chk("prio_idle", 64'(interrupt_vector), 0);

    irq_src = 8'h20; cyc(2); irq_src = 8'h00;
    wait_vec(4'd6, 8);
    irq_src = 8'h01; cyc(2); irq_src = 8'h00;
    cyc(6); chk("nopreempt", 64'(interrupt_vector), 6);
    ack(); chk("np_gap", 64'(interrupt_vector), 0);
    cyc(1); chk("np_gap2", 64'(interrupt_vector), 0);
    cyc(1); chk("np_vec1", 64'(interrupt_vector), 1);
    ack(); cyc(3);
    rd(5'h00, d); chk("np_pend0", d, 64'h0);

    wr(5'h10, 64'hFE);
    irq_src = 8'h01;
    wait_vec(4'd1, 8);
    ack(); chk("lvl_g1", 64'(interrupt_vector), 0);
    cyc(1); chk("lvl_g2", 64'(interrupt_vector), 0);
    cyc(1); chk("lvl_re", 64'(interrupt_vector), 1);
    irq_src = 8'h00;
    cyc(1); ack(); cyc(2);
    chk("lvl_drop", 64'(interrupt_vector), 0);
    rd(5'h00, d); chk("lvl_pend0", d, 64'h0);
    wr(5'h10, 64'hFF);

    wr(5'h08, 64'h00);
    irq_src = 8'h08; cyc(2); irq_src = 8'h00; cyc(4);
    rd(5'h00, d); chk("mask_pend", d, 64'h08);
    chk("mask_vec", 64'(interrupt_vector), 0);
    chk("mask_any", 64'(irq_any), 0);
    wr(5'h00, 64'h08);
    rd(5'h00, d); chk("w1c_pend", d, 64'h0);
    irq_src = 8'h08; cyc(2); irq_src = 8'h00; cyc(4);
    wr(5'h08, 64'h08);
    wait_vec(4'd4, 4);
    irq_src = 8'h08; cyc(2);
    wr(5'h00, 64'h08);
    rd(5'h00, d); chk("w1c_race", d, 64'h08);
    chk("race_vec", 64'(interrupt_vector), 4);

    #2 reset_n = 1'b0;
    #1;
    chk("arst_vec", 64'(interrupt_vector), 0);
    chk("arst_any", 64'(irq_any), 0);
    chk("arst_rdata", bus_read_data, 0);
    irq_src = 8'h00;
    cyc(2);
    reset_n = 1'b1;
    cyc(1);
    rd(5'h08, d); chk("arst_en", d, 64'hFF);
    rd(5'h10, d); chk("arst_mode", d, 64'hFF);
    rd(5'h00, d); chk("arst_pend", d, 64'h0);
    cyc(6); chk("arst_quiet", 64'(interrupt_vector), 0);

    for (int k = 0; k < 3000; k++) begin
      automatic int r = $urandom_range(0, 99);
      automatic int a = $urandom_range(0, 11);
      if (r < 10) irq_src[$urandom_range(0, N - 1)] ^= 1'b1;
      interrupt_ack = ($urandom_range(0, 3) == 0);
      if (a < 9) bus_address = BASE + 64'($urandom_range(0, 31));
      else if (a == 9) bus_address = BASE - 64'($urandom_range(1, 4));
      else if (a == 10) bus_address = BASE + 64'($urandom_range(32, 40));
      else bus_address = {$urandom, $urandom};
      bus_write_data = {$urandom, $urandom};
      bus_read_enable = ($urandom_range(0, 2) == 0);
      bus_write_enable = ($urandom_range(0, 9) == 0);
      if (bus_write_enable && bus_address[4:3] == 2'd2 &&
          $urandom_range(0, 3) != 0)
        bus_write_enable = 1'b0;
      cyc(1);
    end
    interrupt_ack = 1'b0;
    bus_read_enable = 1'b0;
    bus_write_enable = 1'b0;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
